sc_gametimer_reloj: RTL and testbench

SC_GAMETIMER_RELOJ -- requirements
Module: sc_gametimer_reloj

---
 rtl/sc_gametimer_reloj_if.sv | 26 ++
 rtl/sc_gametimer_reloj.sv | 119 +++++++++++
 tb/tb_sc_gametimer_reloj.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_gametimer_reloj_if.sv
// Control and status bundle between the game timer and its user.
// master drives the player/game controls, slave is the timer itself.
interface sc_gametimer_reloj_if;
   logic       start_InLow;
   logic       pause_InHigh;
   logic       lost_InHigh;
   logic       clear_InHigh;
   logic [7:0] reloj_Out;
   logic       tick_Out;
   logic       wrap_Out;
   logic       running_Out;
   logic       frozen_Out;
   logic [1:0] state_dbg;

   // No valid/ready handshake: controls are levels sampled every clock,
   // status outputs are registered and valid every cycle after reset.
   modport master (
      output start_InLow, pause_InHigh, lost_InHigh, clear_InHigh,
      input  reloj_Out, tick_Out, wrap_Out, running_Out, frozen_Out, state_dbg
   );

   modport slave (
      input  start_InLow, pause_InHigh, lost_InHigh, clear_InHigh,
      output reloj_Out, tick_Out, wrap_Out, running_Out, frozen_Out, state_dbg
   );
endinterface

// File: rtl/sc_gametimer_reloj.sv
// Game time counter: a start-button release launches a prescaled count 0..MAX_COUNT
// that can be paused, frozen when the game is lost, and cleared back to idle.
module sc_gametimer_reloj #(
   parameter int unsigned PRESCALE  = 12500000,
   parameter int unsigned MAX_COUNT = 159
) (
   input  logic                    SC_STATEMACHINE_MULTX_CLOCK_50,
   input  logic                    SC_STATEMACHINE_MULTX_RESET_InHigh,
   sc_gametimer_reloj_if.slave     bus
);
   localparam int unsigned PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [7:0] RELOJ_LAST  = 8'(MAX_COUNT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSE  = 2'd2,
      FROZEN = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic [7:0]      reloj_q, reloj_d;
   logic            tick_q, tick_d;
   logic            wrap_q, wrap_d;
   logic            sync1_q, sync2_q, sync_prev_q;
   logic            release_edge;

   // Flops idle high so a button held through reset never looks like a release.
   always_ff @(posedge SC_STATEMACHINE_MULTX_CLOCK_50 or posedge SC_STATEMACHINE_MULTX_RESET_InHigh) begin
      if (SC_STATEMACHINE_MULTX_RESET_InHigh) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         sync_prev_q <= 1'b1;
      end else begin
         sync1_q     <= bus.start_InLow;
         sync2_q     <= sync1_q;
         sync_prev_q <= sync2_q;
      end
   end

   assign release_edge = sync2_q & ~sync_prev_q;

   always_ff @(posedge SC_STATEMACHINE_MULTX_CLOCK_50 or posedge SC_STATEMACHINE_MULTX_RESET_InHigh) begin
      if (SC_STATEMACHINE_MULTX_RESET_InHigh) begin
         state_q <= IDLE;
         pre_q   <= '0;
         reloj_q <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         reloj_q <= reloj_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      reloj_d = reloj_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      if (bus.clear_InHigh) begin
         state_d = IDLE;
         pre_d   = '0;
         reloj_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               pre_d   = '0;
               reloj_d = '0;
               if (release_edge) state_d = RUN;
            end
            RUN: begin
               if (bus.lost_InHigh) begin
                  state_d = FROZEN;
               end else if (bus.pause_InHigh) begin
                  state_d = PAUSE;
               end else if (pre_q == PRE_LAST) begin
                  pre_d  = '0;
                  tick_d = 1'b1;
                  // >= keeps the count bounded even from an out-of-range value.
                  if (reloj_q >= RELOJ_LAST) begin
                     reloj_d = '0;
                     wrap_d  = 1'b1;
                  end else begin
                     reloj_d = reloj_q + 8'd1;
                  end
               end else begin
                  pre_d = pre_q + 1'b1;
               end
            end
            PAUSE: begin
               if (bus.lost_InHigh)        state_d = FROZEN;
               else if (!bus.pause_InHigh) state_d = RUN;
            end
            FROZEN: begin
               state_d = FROZEN;
            end
            default: begin
               state_d = IDLE;
               pre_d   = '0;
               reloj_d = '0;
            end
         endcase
      end
   end

   assign bus.reloj_Out   = reloj_q;
   assign bus.tick_Out    = tick_q;
   assign bus.wrap_Out    = wrap_q;
   assign bus.running_Out = (state_q == RUN);
   assign bus.frozen_Out  = (state_q == FROZEN);
   assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_sc_gametimer_reloj.sv
// Bench for sc_gametimer_reloj with PRESCALE=4, MAX_COUNT=10: vector table,
// directed corner sequences and random stimulus against an elapsed-time model.
module tb_sc_gametimer_reloj;
   localparam int P = 4;
   localparam int M = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   sc_gametimer_reloj_if bus_if ();

   sc_gametimer_reloj #(.PRESCALE(P), .MAX_COUNT(M)) dut (
      .SC_STATEMACHINE_MULTX_CLOCK_50     (clk),
      .SC_STATEMACHINE_MULTX_RESET_InHigh (rst),
      .bus                                (bus_if)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Reference model: time is the number of cycles spent advancing in RUN;
   // the count is that elapsed time divided down and taken modulo MAX+1.
   int   m_mode;   // 0 idle, 1 run, 2 pause, 3 frozen
   int   m_run;
   bit   m_tick, m_wrap;
   logic h1, h2, h3;

   function automatic void m_reset();
      m_mode = 0; m_run = 0; m_tick = 0; m_wrap = 0;
      h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
   endfunction

   function automatic int m_reloj();
      return (m_run / P) % (M + 1);
   endfunction

   function automatic void m_step(input logic st, pa, lo, cl);
      bit rel;
      rel = (h2 == 1'b1) && (h3 == 1'b0);
      h3 = h2; h2 = h1; h1 = st;
      m_tick = 0; m_wrap = 0;
      if (cl) begin
         m_mode = 0; m_run = 0;
      end else if (m_mode == 0) begin
         if (rel) begin m_mode = 1; m_run = 0; end
      end else if (m_mode == 1) begin
         if (lo) m_mode = 3;
         else if (pa) m_mode = 2;
         else begin
            m_run++;
            m_tick = (m_run % P) == 0;
            m_wrap = m_tick && (m_reloj() == 0);
         end
      end else if (m_mode == 2) begin
         if (lo) m_mode = 3;
         else if (!pa) m_mode = 1;
      end
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("m_reloj", int'(bus_if.reloj_Out), m_reloj());
      chk("m_tick", int'(bus_if.tick_Out), int'(m_tick));
      chk("m_wrap", int'(bus_if.wrap_Out), int'(m_wrap));
      chk("m_running", int'(bus_if.running_Out), int'(m_mode == 1));
      chk("m_frozen", int'(bus_if.frozen_Out), int'(m_mode == 3));
   endtask

   task automatic cycle(input logic st, pa, lo, cl);
      @(negedge clk);
      bus_if.start_InLow  = st;
      bus_if.pause_InHigh = pa;
      bus_if.lost_InHigh  = lo;
      bus_if.clear_InHigh = cl;
      @(posedge clk);
      m_step(st, pa, lo, cl);
      #1;
      chk_model();
   endtask

   task automatic press_release();
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      chk("start_running", int'(bus_if.running_Out), 1);
      chk("start_reloj", int'(bus_if.reloj_Out), 0);
   endtask

   typedef struct {
      logic       st, pa, lo, cl;
      logic [7:0] reloj;
      logic       tick, wrap, run, frz;
   } vec_t;

   function automatic vec_t mk(input int st, pa, lo, cl, r, t, w, ru, fz);
      vec_t v;
      v.st = st[0]; v.pa = pa[0]; v.lo = lo[0]; v.cl = cl[0];
      v.reloj = r[7:0]; v.tick = t[0]; v.wrap = w[0]; v.run = ru[0]; v.frz = fz[0];
      return v;
   endfunction

   vec_t tbl[23];
   int   n_ticks, n_wraps, guard;

   initial begin
      // Press/release, first tick, pause at prescaler 2, lost, clear.
      tbl[0] = mk(0,0,0,0, 0,0,0,0,0);
      tbl[1] = mk(1,0,0,0, 0,0,0,0,0);
      tbl[2] = mk(1,0,0,0, 0,0,0,0,0);
      tbl[3] = mk(1,0,0,0, 0,0,0,1,0);
      tbl[4] = mk(1,0,0,0, 0,0,0,1,0);
      tbl[5] = mk(1,0,0,0, 0,0,0,1,0);
      tbl[6] = mk(1,0,0,0, 0,0,0,1,0);
      tbl[7] = mk(1,0,0,0, 1,1,0,1,0);
      tbl[8] = mk(1,0,0,0, 1,0,0,1,0);
      tbl[9] = mk(1,0,0,0, 1,0,0,1,0);
      for (int i = 10; i < 17; i++) tbl[i] = mk(1,1,0,0, 1,0,0,0,0);
      tbl[17] = mk(1,0,0,0, 1,0,0,1,0);
      tbl[18] = mk(1,0,0,0, 1,0,0,1,0);
      tbl[19] = mk(1,0,0,0, 2,1,0,1,0);
      tbl[20] = mk(1,0,1,0, 2,0,0,0,1);
      tbl[21] = mk(0,1,0,0, 2,0,0,0,1);
      tbl[22] = mk(0,0,0,1, 0,0,0,0,0);

      bus_if.start_InLow  = 1'b1;
      bus_if.pause_InHigh = 1'b0;
      bus_if.lost_InHigh  = 1'b0;
      bus_if.clear_InHigh = 1'b0;
      m_reset();
      repeat (2) @(negedge clk);
      chk("rst_reloj", int'(bus_if.reloj_Out), 0);
      chk("rst_tick", int'(bus_if.tick_Out), 0);
      chk("rst_wrap", int'(bus_if.wrap_Out), 0);
      chk("rst_running", int'(bus_if.running_Out), 0);
      chk("rst_frozen", int'(bus_if.frozen_Out), 0);
      rst = 1'b0;

      for (int i = 0; i < 23; i++) begin
         cycle(tbl[i].st, tbl[i].pa, tbl[i].lo, tbl[i].cl);
         chk($sformatf("vec%0d_reloj", i), int'(bus_if.reloj_Out), int'(tbl[i].reloj));
         chk($sformatf("vec%0d_tick", i), int'(bus_if.tick_Out), int'(tbl[i].tick));
         chk($sformatf("vec%0d_wrap", i), int'(bus_if.wrap_Out), int'(tbl[i].wrap));
         chk($sformatf("vec%0d_running", i), int'(bus_if.running_Out), int'(tbl[i].run));
         chk($sformatf("vec%0d_frozen", i), int'(bus_if.frozen_Out), int'(tbl[i].frz));
      end

      // 44 cycles of running: eleven ticks, one wrap on the 10 -> 0 step.
      press_release();
      n_ticks = 0; n_wraps = 0;
      for (int i = 0; i < 44; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b0);
         if (bus_if.tick_Out) begin
            n_ticks++;
            chk("seq_reloj", int'(bus_if.reloj_Out), n_ticks % (M + 1));
         end
         if (bus_if.wrap_Out) begin
            n_wraps++;
            chk("wrap_pos", n_ticks, M + 1);
         end
      end
      chk("run44_ticks", n_ticks, M + 1);
      chk("run44_wraps", n_wraps, 1);
      chk("run44_reloj", int'(bus_if.reloj_Out), 0);

      // Lost on the prescaler terminal cycle at reloj=5: no increment.
      guard = 0;
      while (!(m_reloj() == 5 && (m_run % P) == P - 1) && guard < 200) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b0);
         guard++;
      end
      chk("reach5_budget", int'(guard < 200), 1);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      chk("lost_reloj", int'(bus_if.reloj_Out), 5);
      chk("lost_frozen", int'(bus_if.frozen_Out), 1);
      chk("lost_tick", int'(bus_if.tick_Out), 0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      chk("frozen_hold_reloj", int'(bus_if.reloj_Out), 5);
      chk("frozen_hold_state", int'(bus_if.frozen_Out), 1);

      // Clear from FROZEN, then a fresh start counts from 0.
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      chk("clear_reloj", int'(bus_if.reloj_Out), 0);
      chk("clear_frozen", int'(bus_if.frozen_Out), 0);
      press_release();
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      chk("restart_pre_tick", int'(bus_if.tick_Out), 0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      chk("restart_tick", int'(bus_if.tick_Out), 1);
      chk("restart_reloj", int'(bus_if.reloj_Out), 1);

      // Asynchronous reset between edges at reloj=7.
      guard = 0;
      while (!(m_reloj() == 7 && (m_run % P) == 1) && guard < 200) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b0);
         guard++;
      end
      chk("reach7_budget", int'(guard < 200), 1);
      chk("pre_reset_reloj", int'(bus_if.reloj_Out), 7);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_reloj", int'(bus_if.reloj_Out), 0);
      chk("async_tick", int'(bus_if.tick_Out), 0);
      chk("async_wrap", int'(bus_if.wrap_Out), 0);
      chk("async_running", int'(bus_if.running_Out), 0);
      chk("async_frozen", int'(bus_if.frozen_Out), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_reset();
      repeat (20) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      chk("post_reset_reloj", int'(bus_if.reloj_Out), 0);
      chk("post_reset_running", int'(bus_if.running_Out), 0);

      // Random stimulus against the model.
      begin
         logic st;
         st = 1'b1;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 10) st = ~st;
            cycle(st,
                  logic'($urandom_range(0, 99) < 15),
                  logic'($urandom_range(0, 99) < 2),
                  logic'($urandom_range(0, 99) < 2));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
